// File: rtl/bcd_rtc_if.sv
// Signal bundle for the BCD time-of-day core: controls, load port and display outputs.
// load is a one-cycle strobe with no ready; acceptance or rejection shows up as load_err one cycle later.
interface bcd_rtc_if #(
    parameter int CNT_W = 16
);
    logic             run_en;
    logic [1:0]       time_spd;
    logic             hour_inc;
    logic             min_inc;
    logic             load;
    logic [7:0]       ld_hour;
    logic [7:0]       ld_min;
    logic [7:0]       ld_sec;
    logic             mode_12h;
    logic [7:0]       hour;
    logic [7:0]       min;
    logic [7:0]       sec;
    logic             pm;
    logic             d_or_n;
    logic             sec_tick;
    logic             day_tick;
    logic             load_err;
    logic [CNT_W-1:0] cnt;

    modport master (
        output run_en, time_spd, hour_inc, min_inc, load, ld_hour, ld_min, ld_sec, mode_12h,
        input  hour, min, sec, pm, d_or_n, sec_tick, day_tick, load_err, cnt
    );

    modport slave (
        input  run_en, time_spd, hour_inc, min_inc, load, ld_hour, ld_min, ld_sec, mode_12h,
        output hour, min, sec, pm, d_or_n, sec_tick, day_tick, load_err, cnt
    );
endinterface

// File: rtl/bcd_rtc_core.sv
// BCD hh:mm:ss time-of-day counter with selectable tick rate, load, adjust and 12/24 h display.
// All carries ripple inside one cycle; the prescaler count is exposed on the bus for observation.
module bcd_rtc_core #(
    parameter int DIV0        = 1000,
    parameter int DIV1        = 100,
    parameter int DIV2        = 10,
    parameter int DIV3        = 5,
    parameter int DAY_START   = 8,
    parameter int NIGHT_START = 23,
    parameter int CNT_W       = 16
) (
    input logic       clk,
    input logic       rst,
    bcd_rtc_if.slave  bus
);
    localparam logic [CNT_W-1:0] D0_M1   = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] D1_M1   = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] D2_M1   = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] D3_M1   = CNT_W'(DIV3 - 1);
    localparam logic [6:0]       DAY_B   = 7'(DAY_START);
    localparam logic [6:0]       NIGHT_B = 7'(NIGHT_START);

    // Wraps to 00 at top, otherwise a decimal-adjusted +1.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] top);
        if (v == top) begin
            return 8'h00;
        end else if (v[3:0] == 4'h9) begin
            return {v[7:4] + 4'h1, 4'h0};
        end else begin
            return {v[7:4], v[3:0] + 4'h1};
        end
    endfunction

    logic [7:0]       hr_q, mn_q, sc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hour_inc_q, min_inc_q;
    logic             sec_tick_q, day_tick_q, load_err_q, d_or_n_q;

    logic [CNT_W-1:0] div_m1;
    logic             tick, hour_rise, min_rise, ld_ok, night;
    logic             sec_wrap, min_wrap, day_wrap;
    logic [7:0]       sc_n, mn_n, hr_n, mn_c, hr_c, hour_disp;
    logic [6:0]       hr_bin;

    always_comb begin
        div_m1 = D0_M1;
        case (bus.time_spd)
            2'b00:   div_m1 = D0_M1;
            2'b01:   div_m1 = D1_M1;
            2'b10:   div_m1 = D2_M1;
            default: div_m1 = D3_M1;
        endcase
    end

    assign tick      = bus.run_en && (cnt_q >= div_m1);
    assign hour_rise = bus.hour_inc && !hour_inc_q;
    assign min_rise  = bus.min_inc && !min_inc_q;

    assign ld_ok = (bus.ld_hour[3:0] <= 4'h9) && (bus.ld_hour <= 8'h23) &&
                   (bus.ld_min[3:0]  <= 4'h9) && (bus.ld_min[7:4] <= 4'h5) &&
                   (bus.ld_sec[3:0]  <= 4'h9) && (bus.ld_sec[7:4] <= 4'h5);

    // Tick carry is applied first, then the adjust step on top of it; adjust itself never carries.
    always_comb begin
        sc_n     = tick ? bcd_step(sc_q, 8'h59) : sc_q;
        sec_wrap = tick && (sc_q == 8'h59);
        mn_c     = sec_wrap ? bcd_step(mn_q, 8'h59) : mn_q;
        min_wrap = sec_wrap && (mn_q == 8'h59);
        mn_n     = min_rise ? bcd_step(mn_c, 8'h59) : mn_c;
        hr_c     = min_wrap ? bcd_step(hr_q, 8'h23) : hr_q;
        day_wrap = min_wrap && (hr_q == 8'h23);
        hr_n     = hour_rise ? bcd_step(hr_c, 8'h23) : hr_c;
    end

    assign hr_bin = {3'b000, hr_q[7:4]} * 7'd10 + {3'b000, hr_q[3:0]};
    assign night  = !((hr_bin >= DAY_B) && (hr_bin < NIGHT_B));

    always_comb begin
        hour_disp = hr_q;
        if (bus.mode_12h) begin
            if (hr_q == 8'h00) begin
                hour_disp = 8'h12;
            end else if (hr_q >= 8'h13 && hr_q <= 8'h19) begin
                hour_disp = hr_q - 8'h12;
            end else if (hr_q == 8'h20) begin
                hour_disp = 8'h08;
            end else if (hr_q == 8'h21) begin
                hour_disp = 8'h09;
            end else if (hr_q == 8'h22) begin
                hour_disp = 8'h10;
            end else if (hr_q == 8'h23) begin
                hour_disp = 8'h11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hr_q       <= 8'h00;
            mn_q       <= 8'h00;
            sc_q       <= 8'h00;
            cnt_q      <= '0;
            hour_inc_q <= 1'b0;
            min_inc_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            d_or_n_q   <= 1'b1;
        end else begin
            hour_inc_q <= bus.hour_inc;
            min_inc_q  <= bus.min_inc;
            d_or_n_q   <= night;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                // A rejected load holds every field, prescaler included, for that cycle.
                if (ld_ok) begin
                    hr_q  <= bus.ld_hour;
                    mn_q  <= bus.ld_min;
                    sc_q  <= bus.ld_sec;
                    cnt_q <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else begin
                if (bus.run_en) begin
                    cnt_q <= tick ? '0 : cnt_q + 1'b1;
                end
                sec_tick_q <= tick;
                day_tick_q <= day_wrap;
                hr_q       <= hr_n;
                mn_q       <= mn_n;
                sc_q       <= sc_n;
            end
        end
    end

    assign bus.hour     = hour_disp;
    assign bus.min      = mn_q;
    assign bus.sec      = sc_q;
    assign bus.pm       = (hr_bin >= 7'd12);
    assign bus.d_or_n   = d_or_n_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_tick = day_tick_q;
    assign bus.load_err = load_err_q;
    assign bus.cnt      = cnt_q;
endmodule

// File: tb/tb_bcd_rtc_core.sv
// Directed bench for bcd_rtc_core: a load/display vector table plus hand-written tick, carry and adjust sequences.
module tb_bcd_rtc_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_rtc_if #(.CNT_W(16)) bus ();
    bcd_rtc_core dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] h, m, s;
        logic       mode;
        logic       err;
        logic [7:0] eh, em, es;
        logic       epm, edn;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.ld_hour = h;
        bus.ld_min  = m;
        bus.ld_sec  = s;
        bus.load    = 1'b1;
        step(1);
        bus.load    = 1'b0;
    endtask

    // Steps until sec_tick is seen or the budget expires; n = cycles taken.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.sec_tick && n < limit);
    endtask

    initial begin
        int n;
        int ticks;
        vecs[0]  = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{8'h13, 8'h05, 8'h00, 1'b1, 1'b0, 8'h01, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h13, 8'h60, 8'h00, 1'b1, 1'b1, 8'h01, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 8'h13, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'h1A, 8'h00, 8'h00, 1'b0, 1'b1, 8'h13, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{8'h23, 8'h15, 8'h09, 1'b1, 1'b0, 8'h11, 8'h15, 8'h09, 1'b1, 1'b1};
        vecs[7]  = '{8'h07, 8'h59, 8'h59, 1'b0, 1'b0, 8'h07, 8'h59, 8'h59, 1'b0, 1'b1};
        vecs[8]  = '{8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'h22, 8'h59, 8'h00, 1'b1, 1'b0, 8'h10, 8'h59, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'h12, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h22, 8'h59, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'h20, 8'h00, 8'h00, 1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0};

        bus.run_en   = 1'b0;
        bus.time_spd = 2'b00;
        bus.hour_inc = 1'b0;
        bus.min_inc  = 1'b0;
        bus.load     = 1'b0;
        bus.ld_hour  = 8'h00;
        bus.ld_min   = 8'h00;
        bus.ld_sec   = 8'h00;
        bus.mode_12h = 1'b0;

        // Reset state
        step(2);
        chk("rst_hour", bus.hour, 8'h00);
        chk("rst_min", bus.min, 8'h00);
        chk("rst_sec", bus.sec, 8'h00);
        chk("rst_cnt", bus.cnt, 0);
        chk("rst_pm", bus.pm, 1'b0);
        chk("rst_dn", bus.d_or_n, 1'b1);
        chk("rst_ticks", {bus.sec_tick, bus.day_tick, bus.load_err}, 3'b000);
        bus.mode_12h = 1'b1;
        #1;
        chk("rst_hour_12h", bus.hour, 8'h12);
        bus.mode_12h = 1'b0;
        rst = 1'b0;

        // Fastest rate: 50 clk -> 10 seconds, then freeze
        bus.time_spd = 2'b11;
        bus.run_en   = 1'b1;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus.sec_tick) ticks++;
        end
        chk("t1_ticks", ticks, 10);
        chk("t1_sec", bus.sec, 8'h10);
        bus.run_en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.sec_tick) ticks++;
        end
        chk("t1_frozen_ticks", ticks, 0);
        chk("t1_frozen_sec", bus.sec, 8'h10);

        // Load / validation / display table, time frozen
        for (int i = 0; i < 13; i++) begin
            bus.mode_12h = vecs[i].mode;
            do_load(vecs[i].h, vecs[i].m, vecs[i].s);
            chk($sformatf("v%0d_err", i), bus.load_err, vecs[i].err);
            step(1);
            chk($sformatf("v%0d_err_clr", i), bus.load_err, 1'b0);
            chk($sformatf("v%0d_hour", i), bus.hour, vecs[i].eh);
            chk($sformatf("v%0d_min", i), bus.min, vecs[i].em);
            chk($sformatf("v%0d_sec", i), bus.sec, vecs[i].es);
            chk($sformatf("v%0d_pm", i), bus.pm, vecs[i].epm);
            chk($sformatf("v%0d_dn", i), bus.d_or_n, vecs[i].edn);
        end
        bus.mode_12h = 1'b0;

        // Midnight rollover by tick
        bus.run_en = 1'b1;
        do_load(8'h23, 8'h59, 8'h58);
        wait_tick(20, n);
        chk("t2_gap1", n, 5);
        chk("t2_sec59", bus.sec, 8'h59);
        chk("t2_noday", bus.day_tick, 1'b0);
        wait_tick(20, n);
        chk("t2_gap2", n, 5);
        chk("t2_day", bus.day_tick, 1'b1);
        chk("t2_time", {bus.hour, bus.min, bus.sec}, 24'h000000);
        chk("t2_pm", bus.pm, 1'b0);
        step(1);
        chk("t2_day_pulse", bus.day_tick, 1'b0);
        chk("t2_dn", bus.d_or_n, 1'b1);

        // Night -> day boundary, d_or_n lags by one cycle
        do_load(8'h07, 8'h59, 8'h59);
        wait_tick(20, n);
        chk("t3_gap", n, 5);
        chk("t3_time", {bus.hour, bus.min, bus.sec}, 24'h080000);
        chk("t3_dn_lag", bus.d_or_n, 1'b1);
        step(1);
        chk("t3_dn_day", bus.d_or_n, 1'b0);

        // Other rates and a rate change mid-count
        bus.time_spd = 2'b01;
        do_load(8'h00, 8'h00, 8'h00);
        wait_tick(300, n);
        chk("spd1_gap", n, 100);
        bus.time_spd = 2'b10;
        wait_tick(50, n);
        chk("spd2_gap", n, 10);
        bus.time_spd = 2'b00;
        wait_tick(1100, n);
        chk("spd0_gap", n, 1000);
        step(50);
        bus.time_spd = 2'b11;
        wait_tick(10, n);
        chk("spd_switch_gap", n, 1);

        // Adjust: level held gives one step; no carry, no day_tick
        bus.run_en = 1'b0;
        do_load(8'h10, 8'h20, 8'h30);
        bus.hour_inc = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.day_tick) ticks++;
        end
        bus.hour_inc = 1'b0;
        step(1);
        chk("t5_held", {bus.hour, bus.min, bus.sec}, 24'h112030);
        chk("t5_held_day", ticks, 0);
        do_load(8'h23, 8'h30, 8'h00);
        bus.hour_inc = 1'b1;
        step(1);
        bus.hour_inc = 1'b0;
        chk("t5_wrap", {bus.hour, bus.min, bus.sec}, 24'h003000);
        chk("t5_wrap_day", bus.day_tick, 1'b0);
        do_load(8'h00, 8'h59, 8'h10);
        bus.min_inc = 1'b1;
        step(1);
        bus.min_inc = 1'b0;
        chk("t5_min_wrap", {bus.hour, bus.min, bus.sec}, 24'h000010);

        // Tick carry and hour adjust on the same edge, then reset mid-count
        bus.run_en = 1'b1;
        do_load(8'h10, 8'h59, 8'h59);
        step(4);
        bus.hour_inc = 1'b1;
        step(1);
        bus.hour_inc = 1'b0;
        chk("t6_tick", bus.sec_tick, 1'b1);
        chk("t6_both", {bus.hour, bus.min, bus.sec}, 24'h120000);
        step(2);
        chk("t6_cnt_mid", bus.cnt, 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_time", {bus.hour, bus.min, bus.sec}, 24'h000000);
        chk("t6_rst_cnt", bus.cnt, 0);
        chk("t6_rst_dn", bus.d_or_n, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
